// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: tenths-resolution stopwatch controller with lap hold.
//
// Counts elapsed time as four cascaded BCD digits (M:SS.t, wrapping at
// 9:59.9). A prescaler divides clk into 0.1 s ticks.
//
// Ports
//   clk         in   single clock, all state changes on the rising edge
//   reset       in   synchronous active-high reset
//   start_stop  in   command pulse: toggle run/pause
//   lap         in   command pulse: freeze/release displayed value while running
//   clear       in   command pulse: zero the count, return to idle
//   disp_d0..3  out  displayed BCD digits: tenths, sec units, sec tens, minutes
//   running     out  high in RUN and LAP
//   lap_active  out  high in LAP
//   overflow    out  one-cycle pulse after the count wraps 9:59.9 -> 0:00.0
module stopwatch_ctrl #(
  parameter int unsigned DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] disp_d0,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d3,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_t;

  localparam logic [23:0] DIV_M1 = 24'(DIV - 1);

  state_t      state_q, state_d;
  logic [23:0] pre_q, pre_d;
  logic [3:0]  d0_q, d1_q, d2_q, d3_q;
  logic [3:0]  d0_d, d1_d, d2_d, d3_d;
  logic [3:0]  l0_q, l1_q, l2_q, l3_q;
  logic [3:0]  l0_d, l1_d, l2_d, l3_d;
  logic        ovf_d;

  logic [3:0]  disp0_q, disp1_q, disp2_q, disp3_q;
  logic        run_q, lapact_q, ovf_q;

  logic        active, tick;
  logic        c0, c1, c2, c3;

  always_comb begin
    active = (state_q == S_RUN) || (state_q == S_LAP);
    tick   = active && (pre_q == DIV_M1);

    // Carry chain: cN means digit N wraps on this tick.
    c0 = tick && (d0_q == 4'd9);
    c1 = c0   && (d1_q == 4'd9);
    c2 = c1   && (d2_q == 4'd5);
    c3 = c2   && (d3_q == 4'd9);

    state_d = state_q;
    pre_d   = pre_q;
    d0_d = d0_q; d1_d = d1_q; d2_d = d2_q; d3_d = d3_q;
    l0_d = l0_q; l1_d = l1_q; l2_d = l2_q; l3_d = l3_q;
    ovf_d = c3;

    if (tick) begin
      d0_d = c0 ? '0 : d0_q + 4'd1;
      if (c0) d1_d = c1 ? '0 : d1_q + 4'd1;
      if (c1) d2_d = c2 ? '0 : d2_q + 4'd1;
      if (c2) d3_d = c3 ? '0 : d3_q + 4'd1;
    end

    // Prescaler holds in PAUSE so a resume finishes the partial period.
    if (active) begin
      pre_d = tick ? '0 : pre_q + 24'd1;
    end else if (state_q == S_IDLE) begin
      pre_d = '0;
    end

    // start_stop outranks lap; lap in the same cycle is dropped.
    unique case (state_q)
      S_IDLE: begin
        if (start_stop) state_d = S_RUN;
      end
      S_RUN: begin
        if (start_stop) begin
          state_d = S_PAUSE;
        end else if (lap) begin
          state_d = S_LAP;
          // Capture the count as shown before this edge's tick.
          l0_d = d0_q; l1_d = d1_q; l2_d = d2_q; l3_d = d3_q;
        end
      end
      S_PAUSE: begin
        if (start_stop) state_d = S_RUN;
      end
      S_LAP: begin
        if (start_stop)  state_d = S_PAUSE;
        else if (lap)    state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d = S_IDLE;
      pre_d   = '0;
      d0_d = '0; d1_d = '0; d2_d = '0; d3_d = '0;
      l0_d = '0; l1_d = '0; l2_d = '0; l3_d = '0;
      ovf_d = 1'b0;
    end
  end

  // Outputs are registered from next-state values so they line up with
  // the state register in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      d0_q <= '0; d1_q <= '0; d2_q <= '0; d3_q <= '0;
      l0_q <= '0; l1_q <= '0; l2_q <= '0; l3_q <= '0;
      disp0_q <= '0; disp1_q <= '0; disp2_q <= '0; disp3_q <= '0;
      run_q    <= 1'b0;
      lapact_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      d0_q <= d0_d; d1_q <= d1_d; d2_q <= d2_d; d3_q <= d3_d;
      l0_q <= l0_d; l1_q <= l1_d; l2_q <= l2_d; l3_q <= l3_d;
      if (state_d == S_LAP) begin
        disp0_q <= l0_d; disp1_q <= l1_d; disp2_q <= l2_d; disp3_q <= l3_d;
      end else begin
        disp0_q <= d0_d; disp1_q <= d1_d; disp2_q <= d2_d; disp3_q <= d3_d;
      end
      run_q    <= (state_d == S_RUN) || (state_d == S_LAP);
      lapact_q <= (state_d == S_LAP);
      ovf_q    <= ovf_d;
    end
  end

  assign disp_d0    = disp0_q;
  assign disp_d1    = disp1_q;
  assign disp_d2    = disp2_q;
  assign disp_d3    = disp3_q;
  assign running    = run_q;
  assign lap_active = lapact_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: one instance with DIV=4, one with DIV=2 (used to
// reach the 9:59.9 wrap quickly). A reference model tracks elapsed time as a
// single integer count of tenths and derives the digits arithmetically.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, ss_a = 1'b0, lp_a = 1'b0, clr_a = 1'b0;
  logic rst_b = 1'b1, ss_b = 1'b0, lp_b = 1'b0, clr_b = 1'b0;
  logic [3:0] a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3;
  logic a_run, a_lap, a_ovf, b_run, b_lap, b_ovf;

  stopwatch_ctrl #(.DIV(4)) u_a (
    .clk(clk), .reset(rst_a), .start_stop(ss_a), .lap(lp_a), .clear(clr_a),
    .disp_d0(a_d0), .disp_d1(a_d1), .disp_d2(a_d2), .disp_d3(a_d3),
    .running(a_run), .lap_active(a_lap), .overflow(a_ovf)
  );

  stopwatch_ctrl #(.DIV(2)) u_b (
    .clk(clk), .reset(rst_b), .start_stop(ss_b), .lap(lp_b), .clear(clr_b),
    .disp_d0(b_d0), .disp_d1(b_d1), .disp_d2(b_d2), .disp_d3(b_d3),
    .running(b_run), .lap_active(b_lap), .overflow(b_ovf)
  );

  wire [18:0] out_a = {a_d3, a_d2, a_d1, a_d0, a_run, a_lap, a_ovf};
  wire [18:0] out_b = {b_d3, b_d2, b_d1, b_d0, b_run, b_lap, b_ovf};

  // Command vectors: {reset, start_stop, lap, clear}
  localparam bit [3:0] NONE = 4'b0000, CLR = 4'b0001, LP = 4'b0010,
                       SS = 4'b0100, RST = 4'b1000;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

  typedef struct {
    int mode;
    int pre;
    int live;   // elapsed tenths, 0..5999
    int lapv;   // frozen tenths value shown in LAP
    bit ovf;
  } mdl_t;

  mdl_t ma, mb;
  int errors = 0;
  int checks = 0;

  function automatic mdl_t mstep(mdl_t m, bit [3:0] cmd, int div);
    mdl_t n = m;
    bit rst = cmd[3], ss = cmd[2], lp = cmd[1], clr = cmd[0];
    bit act = (m.mode == M_RUN) || (m.mode == M_LAP);
    bit tick = act && (m.pre == div - 1);
    n.ovf = 1'b0;
    if (rst || clr) begin
      n.mode = M_IDLE; n.pre = 0; n.live = 0; n.lapv = 0;
      return n;
    end
    if (tick) begin
      n.live = (m.live + 1) % 6000;
      n.ovf  = (m.live == 5999);
    end
    if (act) n.pre = (m.pre + 1) % div;
    else if (m.mode == M_IDLE) n.pre = 0;
    if (ss) begin
      if (m.mode == M_IDLE || m.mode == M_PAUSE) n.mode = M_RUN;
      else n.mode = M_PAUSE;
    end else if (lp) begin
      if (m.mode == M_RUN) begin
        n.mode = M_LAP;
        n.lapv = m.live;
      end else if (m.mode == M_LAP) begin
        n.mode = M_RUN;
      end
    end
    return n;
  endfunction

  function automatic logic [18:0] mexp(mdl_t m);
    int v = (m.mode == M_LAP) ? m.lapv : m.live;
    return {4'(v / 600), 4'((v / 100) % 6), 4'((v / 10) % 10), 4'(v % 10),
            (m.mode == M_RUN || m.mode == M_LAP), (m.mode == M_LAP), m.ovf};
  endfunction

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given commands on each instance; both are
  // compared against the model after the edge.
  task automatic step2(input bit [3:0] a, input bit [3:0] b);
    {rst_a, ss_a, lp_a, clr_a} = a;
    {rst_b, ss_b, lp_b, clr_b} = b;
    @(posedge clk);
    ma = mstep(ma, a, 4);
    mb = mstep(mb, b, 2);
    #1;
    chk("model_a", out_a, mexp(ma));
    chk("model_b", out_b, mexp(mb));
    {rst_a, ss_a, lp_a, clr_a} = NONE;
    {rst_b, ss_b, lp_b, clr_b} = NONE;
  endtask

  task automatic stepa(input bit [3:0] a);
    step2(a, NONE);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step2(NONE, NONE);
  endtask

  initial begin
    ma = '{M_IDLE, 0, 0, 0, 1'b0};
    mb = '{M_IDLE, 0, 0, 0, 1'b0};

    // Reset state
    step2(RST, RST);
    chk("reset_a", out_a, 19'h0);
    chk("reset_b", out_b, 19'h0);

    // Start; 40 cycles later 0:01.0
    stepa(SS);
    chk("start_running", {16'h0, out_a[2:0]}, {16'h0, 3'b100});
    idle(40);
    chk("run_40", out_a, {16'h0010, 3'b100});

    // Up to 0:02.3, lap, live keeps counting, release at 0:02.8
    idle(52);
    chk("run_023", out_a, {16'h0023, 3'b100});
    stepa(LP);
    chk("lap_hold", out_a, {16'h0023, 3'b110});
    idle(20);
    chk("lap_hold_20", out_a, {16'h0023, 3'b110});
    stepa(LP);
    chk("lap_release", out_a, {16'h0028, 3'b100});

    // Pause with prescaler held at 2, resume finishes partial period
    idle(3);
    stepa(SS);
    chk("pause", out_a, {16'h0029, 3'b000});
    idle(100);
    chk("pause_100", out_a, {16'h0029, 3'b000});
    stepa(SS);
    chk("resume_0", out_a, {16'h0029, 3'b100});
    idle(1);
    chk("resume_1", out_a, {16'h0029, 3'b100});
    idle(1);
    chk("resume_2", out_a, {16'h0030, 3'b100});

    // DIV=2 instance: count to 9:59.9 and wrap
    step2(NONE, SS);
    idle(11998);
    chk("b_9599", out_b, {16'h9599, 3'b100});
    idle(1);
    chk("b_pre_wrap", out_b, {16'h9599, 3'b100});
    idle(1);
    chk("b_wrap", out_b, {16'h0000, 3'b101});
    idle(1);
    chk("b_wrap_after", out_b, {16'h0000, 3'b100});

    // clear + start_stop + lap while running
    stepa(CLR | SS | LP);
    chk("clear_all", out_a, 19'h0);
    // start_stop + lap together while running -> PAUSE
    stepa(SS);
    idle(5);
    stepa(SS | LP);
    chk("ss_lp_pause", {16'h0, out_a[2:0]}, {16'h0, 3'b000});

    // reset during LAP coincident with a tick
    stepa(CLR);
    stepa(SS);
    stepa(LP);
    idle(2);
    chk("lap_before_rst", {16'h0, out_a[2:0]}, {16'h0, 3'b110});
    stepa(RST);
    chk("rst_in_lap_tick", out_a, 19'h0);
    // reset coincident with a command
    stepa(SS);
    idle(6);
    stepa(RST | SS | LP);
    chk("rst_with_cmd", out_a, 19'h0);

    // Randomized command pulses on both instances
    for (int i = 0; i < 4000; i++) begin
      bit [3:0] ca, cb;
      ca = {($urandom % 300) == 0, ($urandom % 15) == 0,
            ($urandom % 8) == 0, ($urandom % 200) == 0};
      cb = {($urandom % 300) == 0, ($urandom % 15) == 0,
            ($urandom % 8) == 0, ($urandom % 200) == 0};
      step2(ca, cb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DIV, default 10_000_000, meaning clk cycles per 0.1 s tick; legal range 2..2^24-1.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start_stop  input  1  single-cycle command pulse: toggle run/pause.
REQ-005 lap  input  1  single-cycle command pulse: freeze or release the displayed value while running.
REQ-006 clear  input  1  single-cycle command pulse: zero the count and return to idle.
REQ-007 disp_d0 .. disp_d3  output  4 each  displayed BCD digits: tenths, seconds units, seconds tens, minutes.
REQ-008 running  output  1  high in states RUN and LAP.
REQ-009 lap_active  output  1  high in state LAP.
REQ-010 overflow  output  1  one-cycle pulse when the count wraps from 9:59.9 to 0:00.0.

Function
REQ-011 FSM states: IDLE, RUN, PAUSE, LAP; all are registered; outputs are decoded from state and registers only.
REQ-012 IDLE: start_stop goes to RUN; lap is ignored.
REQ-013 RUN: start_stop goes to PAUSE; lap goes to LAP and captures the live count into the lap registers on the same edge.
REQ-014 LAP: lap goes to RUN (display released); start_stop goes to PAUSE (display released).
REQ-015 PAUSE: start_stop goes to RUN; lap is ignored.
REQ-016 clear in any state: go to IDLE; live digits, lap registers and the prescaler are all zeroed on the same edge.
REQ-017 Command priority when pulses coincide: clear > start_stop > lap; a lower-priority pulse in the same cycle is discarded.
REQ-018 Prescaler: 24-bit counter; advances only in RUN and LAP; wraps DIV-1 -> 0.
REQ-019 tick is asserted combinationally in a cycle where the prescaler equals DIV-1 and the state is RUN or LAP.
REQ-020 The prescaler holds its value in PAUSE, so a resume continues the partial tick period; it is zeroed in IDLE.
REQ-021 Live count: four cascaded BCD digits, d0 0..9, d1 0..9, d2 0..5, d3 0..9, each updated on the edge ending a tick cycle.
REQ-022 On tick, d0 increments; a digit that wraps to 0 (d0 at 9, d1 at 9, d2 at 5, d3 at 9) passes a carry that increments the next digit in the same edge.
REQ-023 Wrap from 9:59.9: all digits become 0, counting continues, and overflow is high for exactly the cycle following the wrap edge.
REQ-024 The transition RUN->PAUSE and a tick in the same cycle: the tick is applied, then the state becomes PAUSE.
REQ-025 The transition IDLE->RUN: the first tick occurs DIV cycles after the edge that entered RUN.
REQ-026 disp_d* equal the lap registers in LAP and the live digits in all other states.
REQ-027 Live digits keep counting during LAP.
REQ-028 Digit values never leave their legal BCD ranges; no value above 9, and no d2 value above 5, is ever produced.

Reset
REQ-029 reset has priority over all command inputs.
REQ-030 After reset: state=IDLE; live digits, lap registers and prescaler=0; disp_d*=0; running=0; lap_active=0; overflow=0.
REQ-031 reset asserted mid-count, during LAP, or coincident with a tick or command: the next-edge state is the reset state of REQ-030; the tick or command is discarded.

Verification (DIV=4)
REQ-032 reset; start_stop at cycle 0 -> running=1; digits change on every 4th edge; after 40 cycles disp=0:01.0.
REQ-033 Run to 0:02.3; lap pulse -> lap_active=1; disp held at 0:02.3 while live continues; lap again after 20 cycles -> disp=0:02.8.
REQ-034 Pause with prescaler=2, wait 100 cycles, start_stop -> next increment exactly 2 cycles after resume; digits unchanged during pause.
REQ-035 Preload to 9:59.9 by counting with DIV=2 -> next tick gives disp=0:00.0, one-cycle overflow, and running stays 1.
REQ-036 clear, start_stop and lap in the same cycle while in RUN -> IDLE with all digits 0 and running=0; a separate case with start_stop+lap together -> PAUSE with lap_active=0.
REQ-037 reset asserted during LAP with a tick in the same cycle -> all outputs match REQ-030 on the next edge.
